// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, BCD digit type and digit limits for the countdown timer
package timer_pkg;
  typedef enum logic [2:0] {IDLE, ENTRY, RUN, PAUSE, DONE} state_e;
  typedef logic [3:0] bcd_t;
  localparam bcd_t DIGIT_MAX = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
endpackage

// File: rtl/sec_prescaler.sv
// sec_prescaler: divides clk down to a one-cycle tick every TICKS_PER_SEC enabled cycles
module sec_prescaler #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(TICKS_PER_SEC);
  localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = en && cnt_q == LAST;
    cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/timer_countdown_ctrl.sv
// timer_countdown_ctrl: keypad entry, start/pause/cancel, door interlock and BCD m:ss countdown
module timer_countdown_ctrl
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       digit_valid,
  input  logic [3:0] digit_in,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min,
  output logic       running,
  output logic       done
);
  state_e state_q, state_d;
  bcd_t ones_q, ones_d, tens_q, tens_d, min_q, min_d;
  logic running_q, running_d, done_q, done_d;
  logic in_run, halt, is_zero, dig_ok, start_ok, tick;
  always_comb begin
    in_run   = state_q == RUN;
    halt     = stop || (in_run && !door_closed);
    is_zero  = {min_q, tens_q, ones_q} == 12'd0;
    dig_ok   = digit_valid && digit_in <= DIGIT_MAX && ones_q <= SEC_TENS_MAX &&
               (state_q == IDLE || state_q == ENTRY || state_q == DONE);
    start_ok = start && door_closed && !is_zero && (state_q == ENTRY || state_q == PAUSE);
  end
  // Prescaler freezes on a halting edge so a resumed run keeps its phase.
  sec_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_presc (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (in_run && !halt),
    .clr  (start_ok && state_q == ENTRY),
    .tick (tick)
  );
  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    min_d   = min_q;
    if (halt) begin
      state_d = in_run ? PAUSE : IDLE;
      if (!in_run) {min_d, tens_d, ones_d} = '0;
    end else if (dig_ok) begin
      // DONE always holds 0:00, so the plain shift also yields 0:0d there.
      {min_d, tens_d, ones_d} = {tens_q, ones_q, digit_in};
      state_d = ENTRY;
    end else if (start_ok) begin
      state_d = RUN;
    end else if (tick) begin
      ones_d  = ones_q != 4'd0 ? ones_q - 4'd1 : DIGIT_MAX;
      tens_d  = ones_q != 4'd0 ? tens_q : tens_q != 4'd0 ? tens_q - 4'd1 : SEC_TENS_MAX;
      min_d   = (ones_q | tens_q) != 4'd0 ? min_q : min_q - 4'd1;
      state_d = {min_q, tens_q, ones_q} == 12'h001 ? DONE : RUN;
    end
    running_d = state_d == RUN;
    done_d    = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ones_q    <= '0;
      tens_q    <= '0;
      min_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      min_q     <= min_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end
  assign sec_ones = ones_q;
  assign sec_tens = tens_q;
  assign min      = min_q;
  assign running  = running_q;
  assign done     = done_q;
endmodule

// File: tb/tb_timer_countdown_ctrl.sv
// tb_timer_countdown_ctrl: directed scenario tests for the countdown controller with TICKS_PER_SEC = 4
module tb_timer_countdown_ctrl;
  logic clk = 0, rst_n = 0, digit_valid = 0, start = 0, stop = 0, door_closed = 1;
  logic [3:0] digit_in = 0, sec_ones, sec_tens, min;
  logic running, done;
  logic [11:0] disp;
  int tests = 0, fails = 0;

  assign disp = {min, sec_tens, sec_ones};
  always #5 clk = ~clk;

  timer_countdown_ctrl #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit_in(digit_in),
    .start(start), .stop(stop), .door_closed(door_closed),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min(min), .running(running), .done(done)
  );

  task step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task key(input logic [3:0] d);
    digit_valid = 1; digit_in = d; step(1); digit_valid = 0;
  endtask
  task go();
    start = 1; step(1); start = 0;
  endtask
  task halt();
    stop = 1; step(1); stop = 0;
  endtask

  task test_reset();
    rst_n = 0; digit_valid = 1; digit_in = 4'd3; start = 1; step(2);
    digit_valid = 0; start = 0;
    tests++; if (disp !== 12'h000 || running !== 0 || done !== 0) begin fails++; $display("FAIL reset: disp=%h run=%b done=%b exp 000 0 0", disp, running, done); end
    rst_n = 1; step(1);
  endtask

  task test_entry();
    key(1); key(3); key(0);
    tests++; if (disp !== 12'h130 || running !== 0 || done !== 0) begin fails++; $display("FAIL entry_130: disp=%h run=%b done=%b exp 130 0 0", disp, running, done); end
    key(7);
    tests++; if (disp !== 12'h307) begin fails++; $display("FAIL entry_307: disp=%h exp 307", disp); end
    key(4'hA);
    tests++; if (disp !== 12'h307) begin fails++; $display("FAIL entry_hex_a: disp=%h exp 307", disp); end
    halt();
    tests++; if (disp !== 12'h000 || running !== 0) begin fails++; $display("FAIL entry_cancel: disp=%h run=%b exp 000 0", disp, running); end
  endtask

  task test_reject();
    key(8);
    tests++; if (disp !== 12'h008) begin fails++; $display("FAIL reject_load: disp=%h exp 008", disp); end
    key(2);
    tests++; if (disp !== 12'h008) begin fails++; $display("FAIL reject_ones_gt5: disp=%h exp 008", disp); end
    halt(); key(0); go();
    tests++; if (running !== 0 || disp !== 12'h000) begin fails++; $display("FAIL start_at_zero: run=%b disp=%h exp 0 000", running, disp); end
    halt();
  endtask

  task test_borrow();
    key(1); key(0); key(0); go();
    tests++; if (running !== 1 || disp !== 12'h100) begin fails++; $display("FAIL borrow_start: run=%b disp=%h exp 1 100", running, disp); end
    step(3);
    tests++; if (disp !== 12'h100) begin fails++; $display("FAIL borrow_pre_tick: disp=%h exp 100", disp); end
    step(1);
    tests++; if (disp !== 12'h059 || running !== 1) begin fails++; $display("FAIL borrow_059: disp=%h run=%b exp 059 1", disp, running); end
    key(3);
    tests++; if (disp !== 12'h059) begin fails++; $display("FAIL digit_in_run: disp=%h exp 059", disp); end
    step(7);
    tests++; if (disp !== 12'h057) begin fails++; $display("FAIL borrow_057: disp=%h exp 057", disp); end
    halt();
    tests++; if (disp !== 12'h057 || running !== 0) begin fails++; $display("FAIL borrow_pause: disp=%h run=%b exp 057 0", disp, running); end
    halt();
    tests++; if (disp !== 12'h000) begin fails++; $display("FAIL borrow_cancel: disp=%h exp 000", disp); end
  endtask

  task test_complete();
    key(2); go(); step(4);
    tests++; if (disp !== 12'h001 || running !== 1 || done !== 0) begin fails++; $display("FAIL done_001: disp=%h run=%b done=%b exp 001 1 0", disp, running, done); end
    step(4);
    tests++; if (disp !== 12'h000 || running !== 0 || done !== 1) begin fails++; $display("FAIL done_000: disp=%h run=%b done=%b exp 000 0 1", disp, running, done); end
    step(5);
    tests++; if (disp !== 12'h000 || done !== 1) begin fails++; $display("FAIL done_hold: disp=%h done=%b exp 000 1", disp, done); end
    key(5);
    tests++; if (disp !== 12'h005 || done !== 0 || running !== 0) begin fails++; $display("FAIL done_digit: disp=%h done=%b run=%b exp 005 0 0", disp, done, running); end
    halt();
  endtask

  task test_pause_door();
    key(2); key(1); go(); step(4);
    tests++; if (disp !== 12'h020 || running !== 1) begin fails++; $display("FAIL door_020: disp=%h run=%b exp 020 1", disp, running); end
    step(2); door_closed = 0; step(1);
    tests++; if (disp !== 12'h020 || running !== 0) begin fails++; $display("FAIL door_pause: disp=%h run=%b exp 020 0", disp, running); end
    step(3); go();
    tests++; if (running !== 0 || disp !== 12'h020) begin fails++; $display("FAIL door_open_start: run=%b disp=%h exp 0 020", running, disp); end
    door_closed = 1; step(1); go();
    tests++; if (running !== 1 || disp !== 12'h020) begin fails++; $display("FAIL door_resume: run=%b disp=%h exp 1 020", running, disp); end
    step(1);
    tests++; if (disp !== 12'h020) begin fails++; $display("FAIL door_resume_1: disp=%h exp 020", disp); end
    step(1);
    tests++; if (disp !== 12'h019) begin fails++; $display("FAIL door_resume_019: disp=%h exp 019", disp); end
    halt(); halt();
    tests++; if (disp !== 12'h000 || running !== 0) begin fails++; $display("FAIL door_stop_stop: disp=%h run=%b exp 000 0", disp, running); end
  endtask

  task test_priority();
    key(4); key(5); go(); step(2); halt();
    tests++; if (disp !== 12'h045 || running !== 0) begin fails++; $display("FAIL prio_pause: disp=%h run=%b exp 045 0", disp, running); end
    start = 1; stop = 1; step(1); start = 0; stop = 0;
    tests++; if (disp !== 12'h000 || running !== 0) begin fails++; $display("FAIL prio_start_stop: disp=%h run=%b exp 000 0", disp, running); end
    key(3); digit_valid = 1; digit_in = 4'd4; stop = 1; step(1); digit_valid = 0; stop = 0;
    tests++; if (disp !== 12'h000) begin fails++; $display("FAIL prio_digit_stop: disp=%h exp 000", disp); end
  endtask

  task test_reset_mid();
    key(4); key(5); go(); step(2);
    tests++; if (disp !== 12'h045 || running !== 1) begin fails++; $display("FAIL rst_mid_pre: disp=%h run=%b exp 045 1", disp, running); end
    rst_n = 0; step(1); rst_n = 1;
    tests++; if (disp !== 12'h000 || running !== 0 || done !== 0) begin fails++; $display("FAIL rst_mid: disp=%h run=%b done=%b exp 000 0 0", disp, running, done); end
    go(); step(4);
    tests++; if (running !== 0 || disp !== 12'h000) begin fails++; $display("FAIL rst_mid_start: run=%b disp=%h exp 0 000", running, disp); end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_reject();
    test_borrow();
    test_complete();
    test_pause_door();
    test_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
